// File: rtl/sram_like_mem.sv
`default_nettype none
// ============================================================================
// Module      : sram_like_mem
// Description : Single-outstanding sram-like responder backed by a 32-bit
//               word array. A request is accepted in IDLE, waits LATENCY-1
//               cycles in WAIT and completes in a one-cycle RESP. Writes are
//               byte-masked by size/offset and land at the edge that ends
//               RESP; reads return the full aligned word during RESP.
//               LATENCY must lie in 1..15.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_like_mem #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok
);

  localparam int         C_WORDS  = 1 << DEPTH_LOG2;
  localparam logic [3:0] C_LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q;
  logic [31:0] mem_q [C_WORDS];

  logic                  w_addr_ok;
  logic                  w_data_ok;
  logic                  w_load_rdata;
  logic [DEPTH_LOG2-1:0] w_idx_d;
  logic [DEPTH_LOG2-1:0] w_idx_q;
  logic [3:0]            w_be;
  logic [31:0]           w_bitmask;
  logic [31:0]           w_merged;
  logic                  w_unused_addr;

  // Address bits above the word index only alias, they never select storage.
  assign w_unused_addr = ^addr_q[31:DEPTH_LOG2+2];

  assign w_idx_d = addr_d[DEPTH_LOG2+1:2];
  assign w_idx_q = addr_q[DEPTH_LOG2+1:2];

  // Next-state, handshake outputs and request capture for the IDLE/WAIT/RESP machine.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    w_addr_ok = 1'b0;
    w_data_ok = 1'b0;
    case (state_q)
      ST_IDLE: begin
        w_addr_ok = data_req;
        if (data_req) begin
          wr_d    = data_wr;
          size_d  = data_size;
          addr_d  = data_addr;
          wdata_d = data_wdata;
          cnt_d   = C_LAT_M1;
          state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        w_data_ok = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs are forced low while reset is asserted.
  assign data_addr_ok = w_addr_ok & ~rst;
  assign data_data_ok = w_data_ok & ~rst;
  assign data_rdata   = rdata_q;

  // Read data is fetched on the edge entering RESP so it is valid for the whole RESP cycle.
  assign w_load_rdata = (state_d == ST_RESP) && (state_q != ST_RESP) && !wr_d;

  // Byte enables derived from the latched size and low address bits.
  always_comb begin
    w_be = 4'hF;
    case (size_q)
      2'b00:   w_be = 4'b0001 << addr_q[1:0];
      2'b01:   w_be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'hF;
    endcase
  end

  assign w_bitmask = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
  assign w_merged  = (mem_q[w_idx_q] & ~w_bitmask) | (wdata_q & w_bitmask);

  // State, latency counter and latched request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Read-data register: holds the last read word outside RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 32'd0;
    end else if (w_load_rdata) begin
      rdata_q <= mem_q[w_idx_d];
    end
  end

  // Storage array: cleared by reset, written with the merged word as RESP ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < C_WORDS; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if ((state_q == ST_RESP) && wr_q) begin
      mem_q[w_idx_q] <= w_merged;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_like_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_like_mem
// Description : Scoreboard bench for sram_like_mem with one LATENCY=2 and one
//               LATENCY=1 instance, directed cases plus random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_like_mem;

  localparam int DL2 = 10;
  localparam int NW  = 1 << DL2;

  typedef struct packed {
    logic        is_wr;
    logic [31:0] exp;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic        req_s   [2];
  logic        wr_s    [2];
  logic [1:0]  size_s  [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic [31:0] rdata_s [2];
  logic        aok_s   [2];
  logic        dok_s   [2];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference write: each byte lane is replaced when the access covers it.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] sz, input logic [31:0] a);
    logic [31:0] r;
    int          off;
    r   = old;
    off = int'(a % 4);
    for (int b = 0; b < 4; b++) begin
      if ((sz >= 2'd2) || (sz == 2'd1 && (b / 2) == (off / 2)) || (sz == 2'd0 && b == off))
        r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 2 : 1;
      exp_t        q[$];
      logic [31:0] model [NW];
      logic [31:0] last_rd = 32'd0;
      int          free_at = 0;

      sram_like_mem #(.DEPTH_LOG2(DL2), .LATENCY(LAT)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .data_req     (req_s[g]),
        .data_wr      (wr_s[g]),
        .data_size    (size_s[g]),
        .data_addr    (addr_s[g]),
        .data_wdata   (wdata_s[g]),
        .data_rdata   (rdata_s[g]),
        .data_addr_ok (aok_s[g]),
        .data_data_ok (dok_s[g])
      );

      // Monitor: model acceptance/response timing and data, compare mid-cycle.
      always @(negedge clk) begin : p_mon
        exp_t        e;
        logic        exp_aok;
        logic [31:0] want;
        int          idx;
        if (rst) begin
          n_tests++;
          if (aok_s[g] !== 1'b0 || dok_s[g] !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_outputs dut%0d: addr_ok=%b data_ok=%b, required 0 0", g, aok_s[g], dok_s[g]);
          end
          q.delete();
          for (int i = 0; i < NW; i++) model[i] = 32'd0;
          last_rd = 32'd0;
          free_at = cyc + 1;
        end else begin
          exp_aok = req_s[g] && (cyc >= free_at);
          if (req_s[g] || aok_s[g]) begin
            n_tests++;
            if (aok_s[g] !== exp_aok) begin
              n_fail++;
              $display("FAIL addr_ok dut%0d cyc %0d: got %b, required %b", g, cyc, aok_s[g], exp_aok);
            end
          end
          if (dok_s[g]) begin
            n_tests++;
            if (q.size() == 0) begin
              n_fail++;
              $display("FAIL unexpected_data_ok dut%0d cyc %0d", g, cyc);
            end else begin
              e    = q.pop_front();
              want = e.is_wr ? last_rd : e.exp;
              if (e.due != cyc || rdata_s[g] !== want) begin
                n_fail++;
                $display("FAIL resp dut%0d: rdata=%h cyc=%0d, required rdata=%h cyc=%0d",
                         g, rdata_s[g], cyc, want, e.due);
              end
              if (!e.is_wr) last_rd = e.exp;
            end
          end else if (q.size() != 0 && cyc >= q[0].due) begin
            n_tests++;
            n_fail++;
            $display("FAIL missing_data_ok dut%0d: none by cyc %0d, required at cyc %0d", g, cyc, q[0].due);
            e = q.pop_front();
          end else begin
            n_tests++;
            if (rdata_s[g] !== last_rd) begin
              n_fail++;
              $display("FAIL rdata_hold dut%0d cyc %0d: got %h, required %h", g, cyc, rdata_s[g], last_rd);
            end
          end
          if (exp_aok) begin
            idx     = int'((addr_s[g] >> 2) % NW);
            e.is_wr = wr_s[g];
            e.due   = cyc + LAT;
            e.exp   = 32'd0;
            if (wr_s[g]) model[idx] = merge(model[idx], wdata_s[g], size_s[g], addr_s[g]);
            else         e.exp = model[idx];
            q.push_back(e);
            free_at = cyc + LAT + 1;
          end
        end
      end
    end
  endgenerate

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    return $urandom & 32'hFFFF_003F;
  endfunction

  // One complete transfer; returns the response word and cycles from acceptance to data_ok.
  task automatic xfer(input int d, input logic wr, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output int lat);
    int k;
    @(posedge clk); #1;
    req_s[d] = 1'b1; wr_s[d] = wr; size_s[d] = sz; addr_s[d] = a; wdata_s[d] = wd;
    k = 0;
    do begin @(negedge clk); k++; end while (!aok_s[d] && k < 40);
    if (!aok_s[d]) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout dut%0d addr %h", d, a);
    end
    @(posedge clk); #1;
    req_s[d] = 1'b0; wr_s[d] = 1'($urandom); size_s[d] = 2'($urandom);
    addr_s[d] = $urandom; wdata_s[d] = $urandom;
    k = 0;
    do begin @(negedge clk); k++; end while (!dok_s[d] && k < 40);
    if (!dok_s[d]) begin
      n_tests++; n_fail++;
      $display("FAIL data_ok_timeout dut%0d addr %h", d, a);
    end
    rd  = rdata_s[d];
    lat = k;
  endtask

  // Random traffic; with cont set, data_req stays high and acceptances are counted.
  task automatic traffic(input int d, input int n, input bit cont, input int lat);
    int acc;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      req_s[d]   = cont ? 1'b1 : ($urandom % 3 != 0);
      wr_s[d]    = 1'($urandom);
      size_s[d]  = 2'($urandom);
      addr_s[d]  = rand_addr();
      wdata_s[d] = $urandom;
      @(negedge clk);
      if (aok_s[d]) acc++;
    end
    @(posedge clk); #1;
    req_s[d] = 1'b0;
    repeat (6) @(posedge clk);
    if (cont) chk($sformatf("accept_count_dut%0d", d), 32'(acc), 32'((n + lat) / (lat + 1)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          lat;
    for (int d = 0; d < 2; d++) begin
      req_s[d] = 1'b0; wr_s[d] = 1'b0; size_s[d] = 2'd0; addr_s[d] = 32'd0; wdata_s[d] = 32'd0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_rdata", rdata_s[0], 32'd0);
    chk("reset_addr_ok", 32'(aok_s[0]), 32'd0);
    chk("reset_data_ok", 32'(dok_s[0]), 32'd0);

    // Word write then read, LATENCY=2.
    xfer(0, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, rd, lat);
    chk("wr_latency", 32'(lat), 32'd2);
    xfer(0, 1'b0, 2'd2, 32'h10, 32'h0, rd, lat);
    chk("rd_latency", 32'(lat), 32'd2);
    chk("rd_deadbeef", rd, 32'hDEADBEEF);

    // Byte and halfword merges.
    xfer(0, 1'b1, 2'd2, 32'h20, 32'h11223344, rd, lat);
    xfer(0, 1'b1, 2'd0, 32'h23, 32'hAA000000, rd, lat);
    xfer(0, 1'b1, 2'd1, 32'h20, 32'h00005566, rd, lat);
    xfer(0, 1'b0, 2'd2, 32'h20, 32'h0, rd, lat);
    chk("merge_sb_sh", rd, 32'hAA225566);
    xfer(0, 1'b1, 2'd1, 32'h23, 32'hBEEF0000, rd, lat);
    xfer(0, 1'b0, 2'd0, 32'h21, 32'h0, rd, lat);
    chk("sh_upper_full_word_read", rd, 32'hBEEF5566);

    // Address aliasing.
    xfer(0, 1'b1, 2'd2, 32'h0000_0004, 32'h12345678, rd, lat);
    xfer(0, 1'b0, 2'd2, 32'h0000_1004, 32'h0, rd, lat);
    chk("alias_read", rd, 32'h12345678);

    // LATENCY=1 instance.
    xfer(1, 1'b1, 2'd2, 32'h40, 32'hCAFEF00D, rd, lat);
    chk("lat1_wr_latency", 32'(lat), 32'd1);
    xfer(1, 1'b0, 2'd0, 32'h43, 32'h0, rd, lat);
    chk("lat1_rd_latency", 32'(lat), 32'd1);
    chk("lat1_rd_word", rd, 32'hCAFEF00D);

    // Reset during the WAIT cycle of a write.
    @(posedge clk); #1;
    req_s[0] = 1'b1; wr_s[0] = 1'b1; size_s[0] = 2'd2; addr_s[0] = 32'h8; wdata_s[0] = 32'hFFFFFFFF;
    @(negedge clk);
    chk("rst_mid_accept", 32'(aok_s[0]), 32'd1);
    @(posedge clk); #1;
    req_s[0] = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid_no_data_ok", 32'(dok_s[0]), 32'd0);
    end
    xfer(0, 1'b0, 2'd2, 32'h8, 32'h0, rd, lat);
    chk("rst_mid_write_dropped", rd, 32'h0);

    // Continuous requests: one acceptance per LATENCY+1 cycles.
    traffic(0, 21, 1'b1, 2);
    traffic(1, 20, 1'b1, 1);

    // Random traffic, including requests withdrawn before acceptance.
    traffic(0, 300, 1'b0, 2);
    traffic(1, 300, 1'b0, 1);

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_like_mem.md
SRAM_LIKE_MEM -- requirements
Module: sram_like_mem

Interface
REQ-001 The module SHALL have a parameter DEPTH_LOG2, default 10, giving the log2 of the number of 32-bit words stored.
REQ-002 The module SHALL have a parameter LATENCY, default 2, legal range 1..15, giving the cycles from request acceptance to response.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port data_req, input, 1 bit: the requester asks for a transfer.
REQ-006 The module SHALL have port data_wr, input, 1 bit: 1 means write, 0 means read.
REQ-007 The module SHALL have port data_size, input, 2 bits: 00 is byte, 01 is halfword, 10 and 11 are word.
REQ-008 The module SHALL have port data_addr, input, 32 bits: byte address.
REQ-009 The module SHALL have port data_wdata, input, 32 bits: write data, in lane-aligned positions.
REQ-010 The module SHALL have port data_rdata, output, 32 bits: read response word.
REQ-011 The module SHALL have port data_addr_ok, output, 1 bit: the request is accepted in this cycle.
REQ-012 The module SHALL have port data_data_ok, output, 1 bit: the response or write completion occurs in this cycle.

Function
REQ-013 The module SHALL act as the responder of the sram-like handshake and SHALL hold at most one request outstanding.
REQ-014 The module SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-015 In IDLE, data_addr_ok SHALL equal data_req, combinationally.
REQ-016 In WAIT and RESP, data_addr_ok SHALL be 0.
REQ-017 A request is accepted in cycle T when data_req and data_addr_ok are both 1 in T.
REQ-018 On acceptance, the module SHALL latch wr, size, addr and wdata, load a latency counter with LATENCY-1, and move IDLE to WAIT; when LATENCY=1 it SHALL move IDLE directly to RESP.
REQ-019 In WAIT, the counter SHALL decrement each cycle; on the cycle it reaches 1, the next state SHALL be RESP.
REQ-020 data_data_ok SHALL be 1 only in RESP, which lasts exactly one cycle, which is cycle T+LATENCY; RESP SHALL then return to IDLE unconditionally.
REQ-021 The earliest next acceptance SHALL be in cycle T+LATENCY+1.
REQ-022 Word index SHALL be latched addr[DEPTH_LOG2+1:2]; higher address bits SHALL be ignored, so addresses alias modulo 4*2^DEPTH_LOG2 bytes.
REQ-023 The write byte mask SHALL be: for size 00, one-hot on addr[1:0] (00 gives 0001, 11 gives 1000); for size 01, 0011 when addr[1]=0 and 1100 when addr[1]=1, with addr[0] ignored; for size 10 or 11, 1111.
REQ-024 A write SHALL update only the masked bytes, as new = old & ~mask | wdata & mask, at the clock edge that ends the RESP cycle.
REQ-025 A write's data_rdata SHALL hold its previous value.
REQ-026 A read SHALL present the full aligned word on data_rdata during RESP, ignoring size; byte selection is the requester's job.
REQ-027 A read accepted after a write's RESP cycle SHALL observe the written data.
REQ-028 Outside RESP, data_rdata SHALL hold the last read value.
REQ-029 Changes on the request inputs after acceptance SHALL have no effect on the outstanding transfer.
REQ-030 data_req dropping before acceptance SHALL leave no side effect.

Reset
REQ-031 When rst=1 at a clock edge, the state SHALL become IDLE, the counter SHALL become 0, the latched request SHALL become 0, and data_rdata SHALL become 0.
REQ-032 When rst=1 at a clock edge, every memory word SHALL be cleared to 0.
REQ-033 During rst, data_addr_ok and data_data_ok SHALL be 0.
REQ-034 On reset mid-transfer, the pending transfer SHALL be dropped: no data_data_ok SHALL occur and a pending write SHALL not be performed.

Verification
REQ-035 The bench SHALL check: LATENCY=2, write word 0xDEADBEEF to 0x10, then read 0x10 -> addr_ok in the request cycle; data_ok exactly 2 cycles later; read returns 0xDEADBEEF.
REQ-036 The bench SHALL check: word 0x11223344 at 0x20, then sb 0xAA in lane 3 (addr 0x23, wdata 0xAA000000), then sh 0x5566 at 0x20 -> read 0x20 returns 0xAA225566.
REQ-037 The bench SHALL check: data_req held high continuously -> addr_ok asserted once per LATENCY+1 cycles, and never during WAIT or RESP.
REQ-038 The bench SHALL check: DEPTH_LOG2=10, write 0x12345678 to 0x0000_0004, then read 0x0000_1004 -> returns 0x12345678 (alias).
REQ-039 The bench SHALL check: rst asserted in the WAIT cycle of a write of 0xFFFFFFFF to 0x8 -> no data_ok; a later read of 0x8 returns 0x00000000.
REQ-040 The bench SHALL check: LATENCY=1 -> data_ok in cycle T+1 and next addr_ok no earlier than T+2.
